// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one memory write port among NUM_REQ writers.
// Each grant gives a single write strobe, followed by GAP_CYCLES idle cycles.
module mem_write_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 5,
  parameter  int NUM_REQ    = 4,
  parameter  int GAP_CYCLES = 1,
  localparam int ID_WIDTH   = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          mem_write_en,
  output logic [ADDR_WIDTH-1:0]         mem_write_address,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int         GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_LOAD   = GAP_LOAD_I[3:0];

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [3:0]          gap_cnt;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   win_next;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Winner is the first requester found scanning upward from rr_ptr with wrap.
  always_comb begin
    int idx;
    int nxt;
    win_found  = 1'b0;
    win_id     = '0;
    win_next   = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    idx        = 0;
    nxt        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found       = 1'b1;
        win_id          = idx[ID_WIDTH-1:0];
        nxt             = (idx == NUM_REQ - 1) ? 0 : idx + 1;
        win_next        = nxt[ID_WIDTH-1:0];
        win_onehot[idx] = 1'b1;
        win_addr        = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        win_data        = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      gap_cnt           <= '0;
      ack               <= '0;
      mem_write_en      <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      grant_id          <= '0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state             <= WRITE;
            rr_ptr            <= win_next;
            grant_id          <= win_id;
            ack               <= win_onehot;
            mem_write_en      <= 1'b1;
            mem_write_address <= win_addr;
            mem_write_data    <= win_data;
            busy              <= 1'b1;
          end
        end
        WRITE: begin
          ack          <= '0;
          mem_write_en <= 1'b0;
          // Address/data stay on the bus until the next grant.
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            busy    <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state        <= IDLE;
          ack          <= '0;
          mem_write_en <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0,
// expected writes queued by the driver and matched by per-instance monitors.
module tb_mem_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  localparam logic [AW-1:0] TAB_ADDR [NR] = '{5'd5, 5'd12, 5'd19, 5'd26};
  localparam logic [DW-1:0] TAB_DATA [NR] = '{32'hDEADBEEF, 32'hCAFE0001, 32'h12345678, 32'hA5A55A5A};

  typedef struct {
    int            id;
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req1, req0;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;

  logic [NR-1:0] ack1, ack0;
  logic          en1, en0;
  logic [AW-1:0] addr1, addr0;
  logic [DW-1:0] data1, data0;
  logic [1:0]    gid1, gid0;
  logic          busy1, busy0;

  mem_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(req_addr), .req_data(req_data),
    .ack(ack1), .mem_write_en(en1), .mem_write_address(addr1), .mem_write_data(data1),
    .grant_id(gid1), .busy(busy1)
  );

  mem_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_addr(req_addr), .req_data(req_data),
    .ack(ack0), .mem_write_en(en0), .mem_write_address(addr0), .mem_write_data(data0),
    .grant_id(gid0), .busy(busy0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input string tag, input bit have, input exp_t e,
                       input logic [NR-1:0] ack, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] gid, input logic busy);
    logic [NR-1:0] ea;
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_strobe: got strobe at cycle %0d, expected none", tag, cyc);
      return;
    end
    ea = '0;
    ea[e.id] = 1'b1;
    check({tag, "_cycle"}, cyc, e.cyc);
    check({tag, "_ack"}, ack, ea);
    check({tag, "_addr"}, a, e.addr);
    check({tag, "_data"}, d, e.data);
    check({tag, "_grant_id"}, gid, e.id);
    check({tag, "_busy"}, busy, 1);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      bit   have;
      if (en1 === 1'b1) begin
        have = (q1.size() != 0);
        if (have) e = q1.pop_front();
        score("g1", have, e, ack1, addr1, data1, gid1, busy1);
      end else begin
        check("g1_ack_without_strobe", ack1, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      bit   have;
      if (en0 === 1'b1) begin
        have = (q0.size() != 0);
        if (have) e = q0.pop_front();
        score("g0", have, e, ack0, addr0, data0, gid0, busy0);
      end else begin
        check("g0_ack_without_strobe", ack0, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int id, input int c);
    exp_t e;
    e.id = id; e.cyc = c; e.addr = TAB_ADDR[id]; e.data = TAB_DATA[id];
    q1.push_back(e);
  endtask

  task automatic push0(input int id, input int c);
    exp_t e;
    e.id = id; e.cyc = c; e.addr = TAB_ADDR[id]; e.data = TAB_DATA[id];
    q0.push_back(e);
  endtask

  task automatic wait_idle(input bit use_g0);
    int n;
    n = 0;
    while (((use_g0 ? busy0 : busy1) !== 1'b0) && n < 50) begin
      tick();
      n++;
    end
    check(use_g0 ? "g0_idle_timeout" : "g1_idle_timeout", (n < 50), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    rst_n = 1'b0;
    req1  = '1;
    req0  = '1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = TAB_ADDR[i];
      req_data[i*DW +: DW] = TAB_DATA[i];
    end

    // Reset held 3 cycles with all requests active
    repeat (3) tick();
    check("rst_en", en1, 0);
    check("rst_ack", ack1, 0);
    check("rst_busy", busy1, 0);
    check("rst_addr", addr1, 0);
    check("rst_data", data1, 0);
    check("rst_gid", gid1, 0);
    check("rst_g0_en", en0, 0);
    check("rst_g0_busy", busy0, 0);
    rst_n  = 1'b1;
    req1   = '0;
    req0   = '0;
    mon_on = 1'b1;
    repeat (3) tick();

    // Single write from requester 0
    p = cyc;
    req1 = 4'b0001;
    push1(0, p + 1);
    tick();
    check("t2_busy_write", busy1, 1);
    req1 = '0;
    tick();
    check("t2_busy_gap", busy1, 1);
    check("t2_en_gap", en1, 0);
    tick();
    check("t2_busy_idle", busy1, 0);
    check("t2_addr_held", addr1, 5);
    check("t2_data_held", data1, 32'hDEADBEEF);
    repeat (2) tick();

    // Full contention after a reset: 0,1,2,3,0 every 3 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    p = cyc;
    req1 = 4'hF;
    push1(0, p + 1);
    push1(1, p + 4);
    push1(2, p + 7);
    push1(3, p + 10);
    push1(0, p + 13);
    while (cyc < p + 13) tick();
    req1 = '0;

    // Pointer wrap: grant 2, then 0101 gives 0 then 2
    wait_idle(1'b0);
    p = cyc;
    req1 = 4'b0100;
    push1(2, p + 1);
    tick();
    req1 = '0;
    wait_idle(1'b0);
    p = cyc;
    req1 = 4'b0101;
    push1(0, p + 1);
    push1(2, p + 4);
    while (cyc < p + 4) tick();
    req1 = '0;

    // Reset during GAP: pointer returns to 0, no extra strobe
    wait_idle(1'b0);
    p = cyc;
    req1 = 4'b0010;
    push1(1, p + 1);
    tick();
    req1 = '0;
    tick();
    check("t5_in_gap", busy1, 1);
    rst_n = 1'b0;
    req1  = 4'b1010;
    tick();
    check("t5_busy_after_rst", busy1, 0);
    check("t5_en_after_rst", en1, 0);
    check("t5_gid_after_rst", gid1, 0);
    check("t5_addr_after_rst", addr1, 0);
    rst_n = 1'b1;
    p = cyc;
    push1(1, p + 1);
    tick();
    req1 = '0;
    wait_idle(1'b0);
    repeat (3) tick();

    // GAP_CYCLES=0 instance: 1,3,1,3 every 2 cycles
    wait_idle(1'b1);
    p = cyc;
    req0 = 4'b1010;
    push0(1, p + 1);
    push0(3, p + 3);
    push0(1, p + 5);
    push0(3, p + 7);
    tick();
    tick();
    check("t6_busy_between", busy0, 0);
    while (cyc < p + 7) tick();
    req0 = '0;
    wait_idle(1'b1);
    repeat (4) tick();

    check("g1_queue_drained", q1.size(), 0);
    check("g0_queue_drained", q0.size(), 0);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
